// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths, FSM states, port ids.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              p0_req;
    logic [ADDR_W-1:0] p0_addr;
    logic              p0_ready;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_data_out;

    // arbiter side
    modport slave (
        input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, mem_data_out,
        output p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata,
        output mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );

    // requesters plus memory, as seen from outside the arbiter
    modport master (
        output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata, mem_data_out,
        input  p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata,
        input  mem_address, mem_data_in, mem_write_enable, mem_read_enable
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker; pointer moves to the non-winning port on each advance.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= ~grant[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (port 0, read-only) and load/store (port 1),
// one transaction at a time, round-robin on contention.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    // state  | meaning
    // IDLE   | waiting for a request; ready pulses here for the winner
    // ISSUE  | one-cycle memory enable from the latched transaction
    // WAIT   | read in flight, latency counter running down
    // RESP   | read data registered, rvalid pulsed to the winner

    localparam int CNT_W = 2;

    state_t            state_q, state_d;
    logic [1:0]        req, grant;
    logic              accept;
    logic              capture;
    logic              win_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    assign req = {bus.p1_req, bus.p0_req};

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (accept),
        .grant   (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        accept               = 1'b0;
        capture              = 1'b0;
        bus.p0_ready         = 1'b0;
        bus.p1_ready         = 1'b0;
        bus.p0_rvalid        = 1'b0;
        bus.p1_rvalid        = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.mem_read_enable  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // ready is combinational, so keep it quiet while reset is held
                if ((|req) && !rst) begin
                    accept       = 1'b1;
                    bus.p0_ready = grant[0];
                    bus.p1_ready = grant[1];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.mem_write_enable = we_q;
                bus.mem_read_enable  = ~we_q;
                state_d              = we_q ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.p0_rvalid = (win_q == PORT_FETCH);
                bus.p1_rvalid = (win_q == PORT_LSU);
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q    <= PORT_FETCH;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (accept) begin
                win_q  <= grant[1];
                addr_q <= grant[1] ? bus.p1_addr : bus.p0_addr;
                we_q   <= grant[1] & bus.p1_we;
                if (grant[1]) begin
                    wdata_q <= bus.p1_wdata;
                end
            end
            if (state_q == ST_ISSUE && !we_q) begin
                cnt_q <= CNT_W'(MEM_RD_LAT - 1);
            end else if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            // data is registered on the last WAIT edge so it is already valid with rvalid
            if (capture) begin
                if (win_q == PORT_LSU) begin
                    rdata1_q <= bus.mem_data_out;
                end else begin
                    rdata0_q <= bus.mem_data_out;
                end
            end
        end
    end

    assign bus.mem_address = addr_q;
    assign bus.mem_data_in = wdata_q;
    assign bus.p0_rdata    = rdata0_q;
    assign bus.p1_rdata    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency 256x16 memory model attached.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .MEM_RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem_model [256];
    logic [15:0] mem_dout = 16'h0;

    always @(posedge clk) begin
        if (bus.mem_write_enable) mem_model[bus.mem_address] <= bus.mem_data_in;
        if (bus.mem_read_enable)  mem_dout <= mem_model[bus.mem_address];
    end
    assign bus.mem_data_out = mem_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic prev_rv0 = 1'b0, prev_rv1 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("en_exclusive", 32'(bus.mem_write_enable & bus.mem_read_enable), 32'h0);
            chk("ready_exclusive", 32'(bus.p0_ready & bus.p1_ready), 32'h0);
            chk("p0_rvalid_1cyc", 32'(bus.p0_rvalid & prev_rv0), 32'h0);
            chk("p1_rvalid_1cyc", 32'(bus.p1_rvalid & prev_rv1), 32'h0);
        end
        prev_rv0 = bus.p0_rvalid;
        prev_rv1 = bus.p1_rvalid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    int grants [4];
    int g;

    initial begin
        rst = 1'b1;
        bus.p0_req = 1'b1; bus.p0_addr = 8'h00;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = 8'h00; bus.p1_wdata = 16'h0;
        #3;
        chk("rst_p0_ready", 32'(bus.p0_ready), 32'h0);
        chk("rst_p1_ready", 32'(bus.p1_ready), 32'h0);
        chk("rst_wen", 32'(bus.mem_write_enable), 32'h0);
        chk("rst_ren", 32'(bus.mem_read_enable), 32'h0);
        chk("rst_addr", 32'(bus.mem_address), 32'h0);
        chk("rst_din", 32'(bus.mem_data_in), 32'h0);
        chk("rst_p0_rdata", 32'(bus.p0_rdata), 32'h0);
        chk("rst_p1_rdata", 32'(bus.p1_rdata), 32'h0);
        bus.p0_req = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // p1 write 00 = 1234, then p0 reads it back
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'h00; bus.p1_wdata = 16'h1234;
        #1;
        chk("wr_p1_ready", 32'(bus.p1_ready), 32'h1);
        chk("wr_p0_ready", 32'(bus.p0_ready), 32'h0);
        tick();
        bus.p1_req = 1'b0;
        #1;
        chk("wr_issue_p1_ready", 32'(bus.p1_ready), 32'h0);
        chk("wr_issue_wen", 32'(bus.mem_write_enable), 32'h1);
        chk("wr_issue_ren", 32'(bus.mem_read_enable), 32'h0);
        chk("wr_issue_addr", 32'(bus.mem_address), 32'h00);
        chk("wr_issue_din", 32'(bus.mem_data_in), 32'h1234);
        tick();
        chk("wr_done_wen", 32'(bus.mem_write_enable), 32'h0);
        bus.p0_req = 1'b1; bus.p0_addr = 8'h00;
        #1;
        chk("rd0_p0_ready", 32'(bus.p0_ready), 32'h1);
        tick();
        bus.p0_req = 1'b0;
        #1;
        chk("rd0_issue_ren", 32'(bus.mem_read_enable), 32'h1);
        chk("rd0_issue_addr", 32'(bus.mem_address), 32'h00);
        tick();
        chk("rd0_wait_rvalid", 32'(bus.p0_rvalid), 32'h0);
        chk("rd0_wait_ren", 32'(bus.mem_read_enable), 32'h0);
        tick();
        chk("rd0_resp_rvalid", 32'(bus.p0_rvalid), 32'h1);
        chk("rd0_resp_rdata", 32'(bus.p0_rdata), 32'h1234);
        chk("rd0_resp_p1_rvalid", 32'(bus.p1_rvalid), 32'h0);
        tick();
        chk("rd0_after_rvalid", 32'(bus.p0_rvalid), 32'h0);
        chk("rd0_after_rdata", 32'(bus.p0_rdata), 32'h1234);

        // p1 write FF = BEEF, then p1 read FF
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'hFF; bus.p1_wdata = 16'hBEEF;
        #1;
        chk("wrff_ready", 32'(bus.p1_ready), 32'h1);
        tick();
        bus.p1_req = 1'b0;
        #1;
        chk("wrff_addr", 32'(bus.mem_address), 32'hFF);
        tick();
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'hFF;
        #1;
        chk("rdff_ready", 32'(bus.p1_ready), 32'h1);
        tick();
        bus.p1_req = 1'b0;
        #1;
        chk("rdff_issue_ren", 32'(bus.mem_read_enable), 32'h1);
        chk("rdff_issue_wen", 32'(bus.mem_write_enable), 32'h0);
        chk("rdff_issue_addr", 32'(bus.mem_address), 32'hFF);
        tick();
        chk("rdff_early_rvalid", 32'(bus.p1_rvalid), 32'h0);
        tick();
        chk("rdff_rvalid", 32'(bus.p1_rvalid), 32'h1);
        chk("rdff_rdata", 32'(bus.p1_rdata), 32'hBEEF);
        chk("rdff_p0_rdata_kept", 32'(bus.p0_rdata), 32'h1234);
        chk("rdff_p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
        tick();
        chk("rdff_rvalid_end", 32'(bus.p1_rvalid), 32'h0);

        // fresh reset, both requesting continuously: grants 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.p0_req = 1'b1; bus.p0_addr = 8'h00;
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'h10; bus.p1_wdata = 16'h5555;
        g = 0;
        for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
            #1;
            if (bus.p0_ready) begin grants[g] = 0; g++; end
            else if (bus.p1_ready) begin grants[g] = 1; g++; end
            @(posedge clk);
            #1;
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        chk("rr_grant_count", 32'(g), 32'd4);
        chk("rr_grant0", 32'(grants[0]), 32'd0);
        chk("rr_grant1", 32'(grants[1]), 32'd1);
        chk("rr_grant2", 32'(grants[2]), 32'd0);
        chk("rr_grant3", 32'(grants[3]), 32'd1);
        tick();

        // p0 pulses while busy with a p1 read and drops: no grant, no extra access
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'hFF;
        #1;
        chk("busy_p1_ready", 32'(bus.p1_ready), 32'h1);
        tick();
        bus.p1_req = 1'b0;
        bus.p0_req = 1'b1; bus.p0_addr = 8'h33;
        #1;
        chk("busy_issue_p0_ready", 32'(bus.p0_ready), 32'h0);
        tick();
        bus.p0_req = 1'b0;
        #1;
        chk("busy_wait_p0_ready", 32'(bus.p0_ready), 32'h0);
        tick();
        chk("busy_resp_p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
        tick();
        chk("busy_idle_ren", 32'(bus.mem_read_enable), 32'h0);
        tick();
        chk("busy_no_access_ren", 32'(bus.mem_read_enable), 32'h0);
        chk("busy_no_access_addr", 32'(bus.mem_address), 32'hFF);
        bus.p0_req = 1'b1; bus.p0_addr = 8'h00;
        bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 8'hFF;
        #1;
        chk("busy_ptr_p0_wins", 32'(bus.p0_ready), 32'h1);
        tick();
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        tick(); tick(); tick();

        // reset during WAIT of a p0 read
        bus.p0_req = 1'b1; bus.p0_addr = 8'hFF;
        #1;
        chk("abort_p0_ready", 32'(bus.p0_ready), 32'h1);
        tick();
        bus.p0_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_ren", 32'(bus.mem_read_enable), 32'h0);
        chk("abort_wen", 32'(bus.mem_write_enable), 32'h0);
        chk("abort_p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
        chk("abort_addr", 32'(bus.mem_address), 32'h0);
        chk("abort_p0_rdata", 32'(bus.p0_rdata), 32'h0);
        chk("abort_p1_rdata", 32'(bus.p1_rdata), 32'h0);
        tick();
        chk("abort_held_rvalid", 32'(bus.p0_rvalid), 32'h0);
        rst = 1'b0;
        #1;
        chk("abort_released_rvalid", 32'(bus.p0_rvalid), 32'h0);
        tick();
        chk("abort_after_rvalid", 32'(bus.p0_rvalid), 32'h0);
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 8'h20; bus.p1_wdata = 16'hFFFF;
        #1;
        chk("post_wr_ready", 32'(bus.p1_ready), 32'h1);
        tick();
        bus.p1_req = 1'b0;
        #1;
        chk("post_wr_wen", 32'(bus.mem_write_enable), 32'h1);
        chk("post_wr_addr", 32'(bus.mem_address), 32'h20);
        chk("post_wr_din", 32'(bus.mem_data_in), 32'hFFFF);
        tick();
        bus.p0_req = 1'b1; bus.p0_addr = 8'h20;
        #1;
        chk("post_rd_ready", 32'(bus.p0_ready), 32'h1);
        tick();
        bus.p0_req = 1'b0;
        tick(); tick();
        chk("post_rd_rvalid", 32'(bus.p0_rvalid), 32'h1);
        chk("post_rd_rdata", 32'(bus.p0_rdata), 32'hFFFF);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
